// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store initiator between the EX stage and a word-addressed data memory
// (2^AW words of 32 bits, combinational read, synchronous write on mem_we).
// Byte/half/word requests on byte addresses become word accesses. Sub-word
// stores take a read-modify-write through one extra WRITE cycle. Loads are
// extracted, sign/zero extended and presented as a registered WB result.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid           request present (accepted when req_valid && ready)
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        loads: 1 zero-extend, 0 sign-extend
//   req_addr            byte address; [AW+1:2] word, [1:0] lane, upper ignored
//   req_wdata           right-justified store data
//   req_rd              load destination register
//   ready               unit accepts a request this cycle (state == IDLE)
//   mem_we/addr/wdata   memory write port and word address
//   mem_rdata           combinational memory read data
//   wb_valid/rd/data    registered one-cycle load result
//   misalign_err        registered one-cycle pulse for an illegal request
module mem_access_unit #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [4:0]    req_rd,
  output logic          ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          wb_valid,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          misalign_err
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t        state;
  logic [AW-1:0] merge_addr_p1;
  logic [DW-1:0] merge_data_p1;

  logic          accept_p0;
  logic          illegal_p0;
  logic          word_store_p0;
  logic [DW-1:0] ld_data_p0;
  logic [DW-1:0] st_merge_p0;
  logic          unused_addr_bits;

  // Select the addressed lane of a memory word and extend it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic [31:0]        shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    logic [31:0]        res;
    shifted = 32'(rdata >> {lane, 3'b000});
    b       = shifted[7:0];
    shifted = 32'(rdata >> {lane[1], 4'b0000});
    h       = shifted[15:0];
    case (size)
      2'b00: begin
        ext = b;
        res = uns ? {24'b0, b} : ext;
      end
      2'b01: begin
        ext = h;
        res = uns ? {16'b0, h} : ext;
      end
      default: res = rdata;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/half lane of a memory word with store data.
  function automatic logic [31:0] merge_store(input logic [31:0] rdata,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [4:0]  amt;
    logic [31:0] mask;
    logic [31:0] ins;
    if (size == 2'b00) begin
      amt  = {lane, 3'b000};
      mask = 32'h0000_00FF << amt;
      ins  = {24'b0, wdata[7:0]};
    end else begin
      amt  = {lane[1], 4'b0000};
      mask = 32'h0000_FFFF << amt;
      ins  = {16'b0, wdata[15:0]};
    end
    return (rdata & ~mask) | (ins << amt);
  endfunction

  assign unused_addr_bits = ^req_addr[31:AW+2];

  // Stage p0: request decode, lane extraction and store merge
  assign ready         = (state == IDLE);
  assign accept_p0     = req_valid && ready;
  assign illegal_p0    = (req_size == 2'b11) ||
                         (req_size == 2'b01 && req_addr[0]) ||
                         (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign word_store_p0 = accept_p0 && req_write && !illegal_p0 && (req_size == 2'b10);
  assign ld_data_p0    = extend_load(mem_rdata, req_size, req_addr[1:0], req_unsigned);
  assign st_merge_p0   = merge_store(mem_rdata, req_wdata, req_size, req_addr[1:0]);

  assign mem_we    = (state == WRITE) ? 1'b1 : word_store_p0;
  assign mem_addr  = (state == WRITE) ? merge_addr_p1 : req_addr[AW+1:2];
  assign mem_wdata = (state == WRITE) ? merge_data_p1 : req_wdata;

  // Stage p1: FSM, merge registers and registered write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      merge_addr_p1 <= '0;
      merge_data_p1 <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      misalign_err  <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_p0) begin
            if (illegal_p0) begin
              misalign_err <= 1'b1;
            end else if (!req_write) begin
              wb_valid <= 1'b1;
              wb_rd    <= req_rd;
              wb_data  <= ld_data_p0;
            end else if (req_size != 2'b10) begin
              merge_addr_p1 <= req_addr[AW+1:2];
              merge_data_p1 <= st_merge_p0;
              state         <= WRITE;
            end
          end
        end
        WRITE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the EX stage and the word-addressed data memory (32 x 32-bit, combinational read, synchronous write on `we`). Converts byte-addressed load/store requests of byte, halfword or word size into memory word accesses. Performs read-modify-write for sub-word stores. Sign- or zero-extends load data and presents it as a registered write-back result for the WB stage.

## Interface
- `AW`, 5: memory word-address width. Memory depth is 2^AW words.
- `DW`, 32: data width. Fixed at 32; other values are unsupported.

- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32: byte address; bits [AW+1:2] select the word, bits [1:0] select the lane, bits [31:AW+2] are ignored (address wraps).
- `req_wdata`  in  32: store data, right-justified (byte in [7:0], half in [15:0]).
- `req_rd`  in  5: load destination register, passed through.
- `ready`  out  1: unit can accept a request this cycle (combinational, `state==IDLE`).
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  AW: memory word address.
- `mem_wdata`  out  32: memory write data.
- `mem_rdata`  in  32: memory read data, combinational from `mem_addr`.
- `wb_valid`  out  1: registered; load result valid for one cycle.
- `wb_rd`  out  5: registered destination register.
- `wb_data`  out  32: registered extended load data.
- `misalign_err`  out  1: registered one-cycle pulse for an illegal or misaligned request.

## Operation
- **Accept rule:** a request is accepted on a rising edge where `req_valid && ready`. Little-endian lanes: byte lane = `addr[1:0]`; half lane = `addr[1]`.
- **Legality:** a request is illegal when `req_size==11`, a half has `addr[0]==1`, or a word has `addr[1:0]!=0`. An illegal request:
  - is still accepted;
  - never asserts `mem_we` and never sets `wb_valid`;
  - sets `misalign_err`=1 on the next cycle.
- **FSM:** two states, IDLE and WRITE.
  - In IDLE, `mem_addr` = `req_addr[AW+1:2]` (combinational).
  - **Word store (legal):** `mem_we`=1 and `mem_wdata`=`req_wdata` in the same cycle. Completes in 1 cycle; state stays IDLE.
  - **Load (legal):** the extracted lane of `mem_rdata` is extended per `req_size`/`req_unsigned`. On the edge, it is latched with `wb_valid`=1 and `wb_rd`=`req_rd`. Word loads ignore `req_unsigned`.
  - **Byte/half store (legal):** `mem_we`=0 in IDLE. The merged word (`mem_rdata` with the target lane replaced by the low bits of `req_wdata`) and the word address are latched into internal registers; next state is WRITE.
  - **WRITE:** `ready`=0, `mem_we`=1, `mem_addr`=latched address, `mem_wdata`=latched merge word. Always returns to IDLE after one cycle.
- **Idle outputs:** with no accepted request, `mem_we`=0. `mem_wdata` is a don't-care when `mem_we`=0.
- **Write-back pulses:** `wb_valid` and `misalign_err` are cleared on every edge that does not set them.
- **Pipelining:** a load accepted the cycle after a WRITE state reads the already-updated word. The WRITE edge commits the write, so no forwarding is needed.

## Timing
- **Reset values:** state IDLE, `ready`=1, `mem_we`=0, `wb_valid`=0, `wb_rd`=0, `wb_data`=0, `misalign_err`=0, internal merge registers 0.
- **Reset during WRITE:** state returns to IDLE asynchronously and `mem_we` drops immediately. The pending sub-word store is discarded and memory is unchanged.
- **Latencies:**
  - Load: request cycle N, result (`wb_valid`) in cycle N+1.
  - Word store: memory updated at the end of cycle N.
  - Sub-word store: `ready` low in N+1, memory updated at the end of N+1.
- **Throughput:** one load or word store per cycle; one sub-word store per two cycles.
- **`req_valid` while `ready`=0:** ignored. Upstream holds the request until `ready` is 1.

## Test plan
All scenarios start with memory preloaded so that word i holds i for i = 1..8 and all other words hold 0.

- **Word load:** after reset, load word at addr 0x04 -> next cycle `wb_valid`=1, `wb_data`=0x00000001, `wb_rd` echoed.
- **Byte store:** store byte 0xAB to addr 0x09 -> `ready` low exactly one cycle, `mem_we` high only in the WRITE cycle; word 2 becomes 0x0000AB02.
- **Byte load extension:** then load byte at 0x09 signed -> `wb_data`=0xFFFFFFAB; unsigned -> 0x000000AB.
- **Half store:** store half 0x8001 to 0x0E -> word 3 becomes 0x80010003. Then load half 0x0E signed -> 0xFFFF8001.
- **Illegal requests:** word store to 0x06, then half load at 0x05, then size 11 -> `misalign_err` pulses once per request, memory unchanged, `wb_valid` stays 0.
- **Reset mid-store:** byte store to 0x10, assert `rst` during WRITE -> `mem_we` drops immediately, word 4 stays 0x00000004. Back-to-back word stores to 0x20 and 0x24 with `req_valid` held -> both written on consecutive cycles.
